// File: rtl/bcd_pkg.sv
// Shared constants for the serial BCD add/subtract block: op codes, FSM encoding,
// digit width and a helper that flags non-BCD digits in a packed operand.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_NEG  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  // Operands are zero-extended to the widest legal size (8 digits) before the scan.
  function automatic logic has_bad_digit(input logic [31:0] v, input int n);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n && v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of add (x+y+cin) or subtract (x-y-cin) with decimal carry/borrow.
// Shared by the magnitude pass and the ten's-complement pass of the top level.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               cin,
  input  logic               mode,
  output logic [DIGIT_W-1:0] digit,
  output logic               cout
);

  logic [4:0] sum;
  logic [4:0] sub_rhs;

  always_comb begin
    sum     = {1'b0, x} + {1'b0, y} + {4'd0, cin};
    sub_rhs = {1'b0, y} + {4'd0, cin};
    digit   = '0;
    cout    = 1'b0;
    if (mode == MODE_ADD) begin
      if (sum > 5'd9) begin
        digit = 4'(sum - 5'd10);
        cout  = 1'b1;
      end else begin
        digit = sum[3:0];
      end
    end else begin
      // Borrow whenever the subtrahend (plus incoming borrow) exceeds x.
      if ({1'b0, x} < sub_rhs) begin
        digit = 4'({1'b0, x} + 5'd10 - sub_rhs);
        cout  = 1'b1;
      end else begin
        digit = 4'({1'b0, x} - sub_rhs);
      end
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock LSB first, with an
// optional ten's-complement pass so a negative difference is reported as sign+magnitude.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [DIGIT_W*NDIGITS-1:0] a,
  input  logic [DIGIT_W*NDIGITS-1:0] b,
  output logic                       busy,
  output logic                       done,
  output logic [DIGIT_W*NDIGITS-1:0] result,
  output logic                       negative,
  output logic                       overflow,
  output logic                       error
);

  localparam int W = DIGIT_W * NDIGITS;
  localparam logic [3:0] LAST_DIGIT = 4'(NDIGITS - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           c_q, c_d, sub_q, sub_d;
  logic           neg_q, neg_d, ovf_q, ovf_d, err_q, err_d;
  logic           busy_q, busy_d, done_q, done_d;

  logic [DIGIT_W-1:0] dx, dy, dig;
  logic               dmode, dcout;
  logic               invalid;

  // The NEG pass reuses the digit unit as 0 - r_i - c on the result register.
  assign dx    = (state_q == S_NEG) ? '0 : a_q[DIGIT_W-1:0];
  assign dy    = (state_q == S_NEG) ? res_q[DIGIT_W-1:0] : b_q[DIGIT_W-1:0];
  assign dmode = (state_q == S_NEG) ? MODE_SUB : sub_q;

  bcd_digit_addsub u_digit (
    .x     (dx),
    .y     (dy),
    .cin   (c_q),
    .mode  (dmode),
    .digit (dig),
    .cout  (dcout)
  );

  assign invalid = ((op != OP_ADD) && (op != OP_SUB)) ||
                   has_bad_digit(32'(a), NDIGITS) || has_bad_digit(32'(b), NDIGITS);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sub_d   = sub_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d   = a;
          b_d   = b;
          sub_d = (op == OP_SUB);
          res_d = '0;
          cnt_d = '0;
          c_d   = 1'b0;
          neg_d = 1'b0;
          ovf_d = 1'b0;
          err_d = invalid;
          if (invalid) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        res_d = {dig, res_q[W-1:DIGIT_W]};
        a_d   = a_q >> DIGIT_W;
        b_d   = b_q >> DIGIT_W;
        c_d   = dcout;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_DIGIT) begin
          cnt_d = '0;
          if (sub_q && dcout) begin
            neg_d   = 1'b1;
            c_d     = 1'b0;
            state_d = S_NEG;
          end else begin
            if (!sub_q && dcout) begin
              ovf_d = 1'b1;
              res_d = {NDIGITS{4'd9}};
            end
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_NEG: begin
        res_d = {dig, res_q[W-1:DIGIT_W]};
        c_d   = dcout;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_DIGIT) begin
          cnt_d   = '0;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = res_q;
  assign negative = neg_q;
  assign overflow = ovf_q;
  assign error    = err_q;

endmodule
